layer_colorizer: RTL and testbench
==================================

LAYER_COLORIZER -- requirements
Module: layer_colorizer

Interface
REQ-001 SHALL have parameter NUM_ICONS, default 6: number of icon overlay channels, 1..16.
REQ-002 SHALL have parameter PIX_W, default 2: bits per world/icon pixel code.
REQ-003 SHALL have parameter BLINK_FRAMES, default 30: frame_start pulses per blink half-period, >= 1.
REQ-004 SHALL have port: clock  in  1  pixel clock (75 MHz).
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: video_on  in  1  display-active flag from the timing generator.
REQ-007 SHALL have port: frame_start  in  1  one-cycle pulse per frame.
REQ-008 SHALL have port: world_pixel  in  PIX_W  background map code.
REQ-009 SHALL have port: icon_bus  in  NUM_ICONS*PIX_W  icon codes; channel i at bits [i*PIX_W +: PIX_W].
REQ-010 SHALL have port: pal_wr_valid  in  1  palette write request.
REQ-011 SHALL have port: pal_wr_ready  out  1  palette write acceptance.
REQ-012 SHALL have port: pal_wr_sel  in  1  0 = world palette, 1 = icon palette.
REQ-013 SHALL have port: pal_wr_addr  in  PIX_W  palette entry index.
REQ-014 SHALL have port: pal_wr_data  in  12  colour, {r[3:0],g[3:0],b[3:0]}.
REQ-015 SHALL have port: red, green, blue  out  4 each  registered VGA colour.
REQ-016 SHALL have port: video_on_out  out  1  video_on delayed to align with colour outputs.

Function
REQ-017 SHALL form a 2-stage pipeline: input pixel sampled at edge N appears on red/green/blue and video_on_out at edge N+2.
REQ-018 Stage 1 SHALL select the lowest-index channel with a nonzero code as the winning icon; lower index = higher priority.
REQ-019 Stage 1 SHALL register: the winning code, an icon_hit flag, world_pixel, and video_on.
REQ-020 Stage 2 SHALL output icon_palette[code] when icon_hit is set; otherwise world_palette[world_pixel].
REQ-021 Stage 2 SHALL output 12'h000 whenever the stage-1 video_on is low, regardless of pixel data.
REQ-022 Each palette SHALL hold 2^PIX_W entries of 12 bits.
REQ-023 Icon palette entry 0 SHALL be transparent: writes to it are accepted and stored, but the entry is never displayed.
REQ-024 pal_wr_ready SHALL be a registered signal equal to the inverse of video_on sampled on the previous edge; writes occur only in blanking.
REQ-025 A write SHALL commit on the edge where pal_wr_valid and pal_wr_ready are both 1; the new colour is used by pixels entering stage 2 on the next edge.
REQ-026 If video_on rises on the same edge on which ready is still 1, a pending valid write SHALL still commit; ready falls on the following edge.
REQ-027 While ready is 0, pal_wr_valid SHALL be ignored; no queuing takes place.
REQ-028 If all icon codes are zero, the block SHALL display the world palette, including when NUM_ICONS = 1.

Reset
REQ-029 While reset is low, red, green, blue, video_on_out, pal_wr_ready and all pipeline registers SHALL be 0.
REQ-030 Reset SHALL load world palette {0:12'hFFF, 1:12'h000, 2:12'hC60, 3:12'h0F0}; higher entries are 12'h000.
REQ-031 Reset SHALL load icon palette {0:12'h000, 1:12'h000, 2:12'hF00, 3:12'h00F}; higher entries are 12'h000.
REQ-032 Reset asserted mid-frame SHALL clear state immediately; after release, the first valid output appears 2 edges after video_on is sampled high.

Configuration
REQ-033 With macro LAYER_COLORIZER_BLINK_EN defined, the block SHALL implement a frame counter and blink phase.
REQ-034 With the macro: the counter increments on each frame_start, wraps at BLINK_FRAMES-1, and toggles blink phase on wrap; phase and counter reset to 0.
REQ-035 With the macro: an icon pixel whose winning code is all-ones SHALL be treated as transparent while phase = 0, falling through to lower-priority channels and then the world palette.
REQ-036 Without the macro, no counter SHALL exist, frame_start SHALL be ignored, and all-ones icon codes are always shown.

Verification
REQ-037 Reset release, video_on=1, world_pixel=2, icons all 0 -> {r,g,b}=12'hC60 two edges later.
REQ-038 icon channel 3 = 1 and channel 1 = 2 together -> 12'hF00 (channel 1 wins).
REQ-039 video_on=0, valid write sel=1, addr=2, data 12'h0AA -> accepted; next active pixel with icon code 2 -> 12'h0AA.
REQ-040 Write presented while video_on has been 1 for two or more cycles -> ready=0, palette unchanged, colour stays 12'hF00.
REQ-041 BLINK_EN with BLINK_FRAMES=2, icon code 3 -> 12'h00F shown only in frames 2-3, 6-7, and so on; otherwise the world colour.
REQ-042 Reset asserted mid-line with video_on=1 -> outputs 0 immediately; after release, correct colour resumes after exactly 2 edges.

Source files
------------

// File: rtl/layer_colorizer.sv
// layer_colorizer: two-stage VGA colour pipeline.
// Stage 1 picks the highest-priority (lowest-index) nonzero icon channel.
// Stage 2 looks the pixel up in the icon or world palette.
// Palettes are writable only during blanking.
// Optional blink feature: define LAYER_COLORIZER_BLINK_EN. While the blink
// phase is 0, all-ones icon codes are hidden.
module layer_colorizer #(
  parameter int NUM_ICONS    = 6,
  parameter int PIX_W        = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       video_on,
  input  logic                       frame_start,
  input  logic [PIX_W-1:0]           world_pixel,
  input  logic [NUM_ICONS*PIX_W-1:0] icon_bus,
  input  logic                       pal_wr_valid,
  output logic                       pal_wr_ready,
  input  logic                       pal_wr_sel,
  input  logic [PIX_W-1:0]           pal_wr_addr,
  input  logic [11:0]                pal_wr_data,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue,
  output logic                       video_on_out
);

  localparam int PAL_N = 1 << PIX_W;

  logic [NUM_ICONS-1:0][PIX_W-1:0] icons;
  assign icons = icon_bus;

  function automatic logic [11:0] world_rst(input int i);
    case (i)
      0:       return 12'hFFF;
      2:       return 12'hC60;
      3:       return 12'h0F0;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] icon_rst(input int i);
    case (i)
      2:       return 12'hF00;
      3:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  logic [11:0]      wpal_q [PAL_N];
  logic [11:0]      wpal_d [PAL_N];
  logic [11:0]      ipal_q [PAL_N];
  logic [11:0]      ipal_d [PAL_N];
  logic             ready_q, ready_d;
  logic             hit_q, hit_d;
  logic [PIX_W-1:0] code_q, code_d;
  logic [PIX_W-1:0] world_q, world_d;
  logic             von1_q, von1_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             von2_q, von2_d;
  logic             hide_ones;

`ifdef LAYER_COLORIZER_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // frame counter: wraps at BLINK_FRAMES-1 and flips the blink phase on wrap
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // blink state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign hide_ones = ~phase_q;
`else
  logic unused_blink;
  assign unused_blink = frame_start & (BLINK_FRAMES > 0);
  assign hide_ones    = 1'b0;
`endif

  // next state: palette write port, priority select (stage 1), lookup (stage 2)
  always_comb begin
    wpal_d  = wpal_q;
    ipal_d  = ipal_q;
    hit_d   = 1'b0;
    code_d  = '0;
    ready_d = ~video_on;
    if (pal_wr_valid && ready_q) begin
      if (pal_wr_sel) ipal_d[pal_wr_addr] = pal_wr_data;
      else            wpal_d[pal_wr_addr] = pal_wr_data;
    end
    // descending scan so that the lowest qualifying channel is assigned last
    for (int i = NUM_ICONS - 1; i >= 0; i--) begin
      if ((icons[i] != '0) && !(hide_ones && (icons[i] == '1))) begin
        hit_d  = 1'b1;
        code_d = icons[i];
      end
    end
    world_d = world_pixel;
    von1_d  = video_on;
    // a hit always carries a nonzero code, so icon entry 0 is never shown
    rgb_d   = !von1_q ? 12'h000 : (hit_q ? ipal_q[code_q] : wpal_q[world_q]);
    von2_d  = von1_q;
  end

  // state registers; palettes reload their default colours on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PAL_N; i++) begin
        wpal_q[i] <= world_rst(i);
        ipal_q[i] <= icon_rst(i);
      end
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      code_q  <= '0;
      world_q <= '0;
      von1_q  <= 1'b0;
      rgb_q   <= 12'h000;
      von2_q  <= 1'b0;
    end else begin
      wpal_q  <= wpal_d;
      ipal_q  <= ipal_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      code_q  <= code_d;
      world_q <= world_d;
      von1_q  <= von1_d;
      rgb_q   <= rgb_d;
      von2_q  <= von2_d;
    end
  end

  assign pal_wr_ready = ready_q;
  assign red          = rgb_q[11:8];
  assign green        = rgb_q[7:4];
  assign blue         = rgb_q[3:0];
  assign video_on_out = von2_q;

endmodule

// File: tb/tb_layer_colorizer.sv
// Bench for layer_colorizer. It runs a table of pixel vectors followed by
// hand-written sequences: palette writes, the ready timing, mid-line reset
// and blink. Expected colours flow through a two-deep scoreboard queue.
module tb_layer_colorizer;

`ifdef LAYER_COLORIZER_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        video_on = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  world_pixel = '0;
  logic [11:0] icon_bus = '0;
  logic        pal_wr_valid = 1'b0;
  logic        pal_wr_ready;
  logic        pal_wr_sel = 1'b0;
  logic [1:0]  pal_wr_addr = '0;
  logic [11:0] pal_wr_data = '0;
  logic [3:0]  red, green, blue;
  logic        video_on_out;

  layer_colorizer #(.NUM_ICONS(6), .PIX_W(2), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .video_on(video_on), .frame_start(frame_start),
    .world_pixel(world_pixel), .icon_bus(icon_bus),
    .pal_wr_valid(pal_wr_valid), .pal_wr_ready(pal_wr_ready),
    .pal_wr_sel(pal_wr_sel), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
    .red(red), .green(green), .blue(blue), .video_on_out(video_on_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] rgb;
    logic        von;
    string       nm;
  } sb_t;

  typedef struct {
    logic        von;
    logic [1:0]  world;
    logic [11:0] icons;
    logic [11:0] exp;
    string       nm;
  } vec_t;

  sb_t  sbq[$];
  vec_t tbl[11];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic logic [11:0] ic(input int ch, input logic [1:0] code);
    logic [11:0] v;
    v = '0;
    v[ch*2 +: 2] = code;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // one pixel cycle: check the output due now, then drive and record the new pixel
  task automatic cyc(input logic von, input logic [1:0] wp, input logic [11:0] icv,
                     input logic [11:0] e, input string nm);
    sb_t s;
    @(negedge clock);
    if (sbq.size() >= 2) begin
      s = sbq.pop_front();
      chk({s.nm, "_rgb"}, {red, green, blue}, s.rgb);
      chk({s.nm, "_von"}, {11'b0, video_on_out}, {11'b0, s.von});
    end
    video_on    = von;
    world_pixel = wp;
    icon_bus    = icv;
    s.rgb = e;
    s.von = von;
    s.nm  = nm;
    sbq.push_back(s);
  endtask

  task automatic blank();
    cyc(1'b0, 2'd0, 12'h000, 12'h000, "blank");
  endtask

  task automatic pal_req(input logic v, input logic sel, input logic [1:0] a, input logic [11:0] d);
    pal_wr_valid = v;
    pal_wr_sel   = sel;
    pal_wr_addr  = a;
    pal_wr_data  = d;
  endtask

  initial begin
    sb_t dummy;
    tbl[0]  = '{1'b1, 2'd2, 12'h000,            12'hC60, "world2"};
    tbl[1]  = '{1'b1, 2'd0, 12'h000,            12'hFFF, "world0"};
    tbl[2]  = '{1'b1, 2'd1, 12'h000,            12'h000, "world1"};
    tbl[3]  = '{1'b1, 2'd3, 12'h000,            12'h0F0, "world3"};
    tbl[4]  = '{1'b1, 2'd0, ic(3,1) | ic(1,2),  12'hF00, "prio_ch1"};
    tbl[5]  = '{1'b1, 2'd0, ic(0,3) | ic(2,2),  BL ? 12'hF00 : 12'h00F, "ones_ch0"};
    tbl[6]  = '{1'b0, 2'd2, ic(1,2),            12'h000, "blanked"};
    tbl[7]  = '{1'b1, 2'd0, ic(5,1),            12'h000, "ch5_code1"};
    tbl[8]  = '{1'b1, 2'd3, ic(5,2),            12'hF00, "ch5_code2"};
    tbl[9]  = '{1'b1, 2'd2, ic(0,2) | ic(5,3),  12'hF00, "ch0_over_ch5"};
    tbl[10] = '{1'b1, 2'd3, ic(4,3),            BL ? 12'h0F0 : 12'h00F, "ones_world"};

    // outputs held at zero during reset
    repeat (3) @(negedge clock);
    chk("rst_rgb",   {red, green, blue}, 12'h000);
    chk("rst_von",   {11'b0, video_on_out}, 12'h000);
    chk("rst_ready", {11'b0, pal_wr_ready}, 12'h000);
    #2 reset = 1'b1;

    foreach (tbl[i]) cyc(tbl[i].von, tbl[i].world, tbl[i].icons, tbl[i].exp, tbl[i].nm);
    blank(); blank();

    // blanking write to icon entry 2; icon entry 0 is written but never shown
    chk("ready_blank", {11'b0, pal_wr_ready}, 12'h001);
    pal_req(1'b1, 1'b1, 2'd2, 12'h0AA);
    blank();
    pal_req(1'b1, 1'b1, 2'd0, 12'hFFF);
    blank();
    pal_req(1'b0, 1'b0, 2'd0, 12'h000);
    cyc(1'b1, 2'd0, ic(2,2), 12'h0AA, "icon2_new");
    cyc(1'b1, 2'd3, 12'h000, 12'h0F0, "icon0_hidden");
    blank(); blank();
    pal_req(1'b1, 1'b1, 2'd2, 12'hF00);
    blank();
    pal_req(1'b0, 1'b0, 2'd0, 12'h000);

    // during active video writes are refused
    cyc(1'b1, 2'd0, ic(2,2), 12'hF00, "active_a");
    cyc(1'b1, 2'd0, ic(2,2), 12'hF00, "active_b");
    chk("ready_active", {11'b0, pal_wr_ready}, 12'h000);
    pal_req(1'b1, 1'b1, 2'd2, 12'h0AA);
    cyc(1'b1, 2'd0, ic(2,2), 12'hF00, "refused_a");
    cyc(1'b1, 2'd0, ic(2,2), 12'hF00, "refused_b");
    pal_req(1'b0, 1'b0, 2'd0, 12'h000);
    cyc(1'b1, 2'd0, ic(2,2), 12'hF00, "refused_c");
    blank(); blank();

    // write presented on the same edge video_on rises still commits
    chk("ready_pre_rise", {11'b0, pal_wr_ready}, 12'h001);
    cyc(1'b1, 2'd1, 12'h000, 12'h123, "rise_write_a");
    pal_req(1'b1, 1'b0, 2'd1, 12'h123);
    cyc(1'b1, 2'd1, 12'h000, 12'h123, "rise_write_b");
    pal_req(1'b0, 1'b0, 2'd0, 12'h000);
    chk("ready_post_rise", {11'b0, pal_wr_ready}, 12'h000);
    cyc(1'b1, 2'd2, 12'h000, 12'hC60, "line_a");
    cyc(1'b1, 2'd2, 12'h000, 12'hC60, "line_b");

    // mid-line reset clears outputs at once and restores default palettes
    #2 reset = 1'b0;
    #1;
    chk("midrst_rgb",   {red, green, blue}, 12'h000);
    chk("midrst_von",   {11'b0, video_on_out}, 12'h000);
    chk("midrst_ready", {11'b0, pal_wr_ready}, 12'h000);
    sbq.delete();
    @(posedge clock); #1;
    chk("midrst_hold", {red, green, blue}, 12'h000);
    #2 reset = 1'b1;
    dummy.rgb = 12'h000; dummy.von = 1'b0; dummy.nm = "post_rst_early";
    sbq.push_back(dummy);
    cyc(1'b1, 2'd2, 12'h000, 12'hC60, "post_rst_first");
    cyc(1'b1, 2'd1, 12'h000, 12'h000, "post_rst_world1");
    cyc(1'b1, 2'd0, ic(2,3), 12'h00F & {12{BL ? 1'b0 : 1'b1}} | (BL ? 12'hFFF : 12'h000),
        "post_rst_icon3");
    blank(); blank();

    // blink: with BLINK_FRAMES=2, all-ones codes show only in frames 2-3, 6-7
    for (int f = 0; f < 8; f++) begin
      if (f > 0) begin
        frame_start = 1'b1;
        blank();
        frame_start = 1'b0;
      end
      cyc(1'b1, 2'd3, ic(0,3), (BL && ((f / 2) % 2 == 0)) ? 12'h0F0 : 12'h00F, $sformatf("frame%0d_a", f));
      cyc(1'b1, 2'd3, ic(0,3), (BL && ((f / 2) % 2 == 0)) ? 12'h0F0 : 12'h00F, $sformatf("frame%0d_b", f));
    end
    blank(); blank(); blank();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
